// File: rtl/pkt_rr_arb_af.sv
// Packet-boundary round-robin arbiter merging NUM_IN Avalon-ST sources onto one ready-less stream.
// Optional macro PKT_ARB_NOGAP_EN: re-arbitrate on the accepted eop beat for zero-bubble packet handover.
module pkt_rr_arb_af #(
    parameter int NUM_IN = 4,
    parameter int DWIDTH = 512,
    parameter int EWIDTH = 6,
    parameter int SWIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_sop,
    input  logic [NUM_IN-1:0]        in_eop,
    input  logic [NUM_IN*EWIDTH-1:0] in_empty,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [EWIDTH-1:0]        out_empty,
    output logic                     out_valid,
    output logic [SWIDTH-1:0]        out_src,
    input  logic                     out_almost_full,
    output logic [NUM_IN-1:0]        cur_grant
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]        state;
    logic [SWIDTH-1:0] ptr;
    logic [SWIDTH-1:0] gidx;
    logic [SWIDTH-1:0] win_idle;
    logic              accept;
    logic              accept_eop;
    logic [DWIDTH-1:0] g_data;
    logic [EWIDTH-1:0] g_empty;

    function automatic logic [SWIDTH-1:0] wrap_inc(input logic [SWIDTH-1:0] v);
        return (v == SWIDTH'(NUM_IN - 1)) ? '0 : v + 1'b1;
    endfunction

    // First requester at or after start, modulo NUM_IN.
    function automatic logic [SWIDTH-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                                  input logic [SWIDTH-1:0] start);
        logic [SWIDTH-1:0] idx;
        logic [SWIDTH-1:0] win;
        logic              found;
        idx   = start;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return win;
    endfunction

    function automatic logic [NUM_IN-1:0] onehot(input logic [SWIDTH-1:0] v);
        logic [NUM_IN-1:0] oh;
        oh    = '0;
        oh[v] = 1'b1;
        return oh;
    endfunction

    assign win_idle   = rr_pick(in_valid, ptr);
    assign in_ready   = (state == LOCK) ? cur_grant : '0;
    assign accept     = (state == LOCK) && in_valid[gidx];
    assign accept_eop = accept && in_eop[gidx];
    assign g_data     = in_data[int'(gidx)*DWIDTH +: DWIDTH];
    assign g_empty    = in_empty[int'(gidx)*EWIDTH +: EWIDTH];

`ifdef PKT_ARB_NOGAP_EN
    logic [NUM_IN-1:0] others;
    logic [SWIDTH-1:0] win_eop;
    // The finishing source is masked out so it cannot win its own handover.
    assign others  = in_valid & ~cur_grant;
    assign win_eop = rr_pick(others, ptr);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cur_grant <= '0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            out_valid <= accept;
            out_sop   <= accept && in_sop[gidx];
            out_eop   <= accept_eop;
            out_empty <= accept ? g_empty : '0;
            if (accept) begin
                out_data <= g_data;
                out_src  <= gidx;
            end

            case (state)
                IDLE: begin
                    if (!out_almost_full && |in_valid) begin
                        state     <= LOCK;
                        gidx      <= win_idle;
                        cur_grant <= onehot(win_idle);
                        ptr       <= wrap_inc(win_idle);
                    end
                end
                LOCK: begin
                    if (accept_eop) begin
`ifdef PKT_ARB_NOGAP_EN
                        if (!out_almost_full && |others) begin
                            gidx      <= win_eop;
                            cur_grant <= onehot(win_eop);
                            ptr       <= wrap_inc(win_eop);
                        end else begin
                            state     <= IDLE;
                            cur_grant <= '0;
                        end
`else
                        state     <= IDLE;
                        cur_grant <= '0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    cur_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rr_arb_af.sv
// Directed, table-driven bench for pkt_rr_arb_af (default parameters), plus reset, fairness and handover sequences.
module tb_pkt_rr_arb_af;

    localparam int NUM_IN = 4;
    localparam int DWIDTH = 512;
    localparam int EWIDTH = 6;
    localparam int SWIDTH = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_IN*DWIDTH-1:0] in_data;
    logic [NUM_IN-1:0]        in_sop;
    logic [NUM_IN-1:0]        in_eop;
    logic [NUM_IN*EWIDTH-1:0] in_empty;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [DWIDTH-1:0]        out_data;
    logic                     out_sop;
    logic                     out_eop;
    logic [EWIDTH-1:0]        out_empty;
    logic                     out_valid;
    logic [SWIDTH-1:0]        out_src;
    logic                     out_almost_full;
    logic [NUM_IN-1:0]        cur_grant;

    int checks = 0;
    int errors = 0;

    pkt_rr_arb_af #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .EWIDTH(EWIDTH), .SWIDTH(SWIDTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .out_valid(out_valid),
        .out_src(out_src), .out_almost_full(out_almost_full), .cur_grant(cur_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] vld;
        logic [3:0] sop;
        logic [3:0] eop;
        logic       af;
        logic [7:0] dat;
        logic [5:0] emp;
        logic       e_valid;
        logic [1:0] e_src;
        logic       e_sop;
        logic       e_eop;
        logic [5:0] e_emp;
        logic [7:0] e_data;
        logic [3:0] e_grant;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] sop, input logic [3:0] eop,
                                input logic af, input logic [7:0] dat, input logic [5:0] emp,
                                input logic ev, input logic [1:0] es, input logic esop,
                                input logic eeop, input logic [5:0] eemp, input logic [7:0] ed,
                                input logic [3:0] eg);
        vec_t v;
        v = '{vld, sop, eop, af, dat, emp, ev, es, esop, eeop, eemp, ed, eg};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Source i carries {i, dat} in its low 16 data bits; only valid sources carry emp.
    task automatic drive(input logic [3:0] vld, input logic [3:0] sop, input logic [3:0] eop,
                         input logic af, input logic [7:0] dat, input logic [5:0] emp);
        in_valid        = vld;
        in_sop          = sop;
        in_eop          = eop;
        out_almost_full = af;
        in_data         = '0;
        in_empty        = '1;
        for (int i = 0; i < NUM_IN; i++) begin
            in_data[i*DWIDTH +: 16] = {8'(i), dat};
            if (vld[i]) in_empty[i*EWIDTH +: EWIDTH] = emp;
        end
    endtask

    task automatic do_reset();
        drive(4'b0, 4'b0, 4'b0, 1'b0, 8'h00, 6'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[26];

    initial begin
        int         vcnt;
        int         b[4];
        int         cnt[4];
        int         pkts;
        int         sops;
        logic [3:0] rdy;
        logic [3:0] sp;
        logic [3:0] ep;
        logic       nv[6];
        logic [1:0] ns[6];

        // cyc: vld sop eop af dat emp | valid src sop eop emp data grant
        tbl[0]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'hA1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0100);
        tbl[1]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'hA1, 0, 1, 2, 1, 0, 0, 8'hA1, 4'b0100);
        tbl[2]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 8'hA2, 0, 1, 2, 0, 0, 0, 8'hA2, 4'b0100);
        tbl[3]  = mk(4'b0100, 4'b0000, 4'b0100, 0, 8'hA3, 5, 1, 2, 0, 1, 5, 8'hA3, 4'b0000);
        tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000);
        tbl[5]  = mk(4'b0001, 4'b0001, 4'b0000, 0, 8'hB1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0001);
        tbl[6]  = mk(4'b0001, 4'b0001, 4'b0000, 0, 8'hB1, 0, 1, 0, 1, 0, 0, 8'hB1, 4'b0001);
        tbl[7]  = mk(4'b1110, 4'b1110, 4'b0000, 0, 8'hEE, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0001);
        tbl[8]  = mk(4'b1110, 4'b1110, 4'b0000, 0, 8'hEE, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0001);
        tbl[9]  = mk(4'b1110, 4'b1110, 4'b0000, 0, 8'hEE, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0001);
        tbl[10] = mk(4'b1110, 4'b1110, 4'b0000, 0, 8'hEE, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0001);
        tbl[11] = mk(4'b0001, 4'b0000, 4'b0001, 0, 8'hB2, 0, 1, 0, 0, 1, 0, 8'hB2, 4'b0000);
        tbl[12] = mk(4'b0010, 4'b0010, 4'b0010, 0, 8'hC1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0010);
        tbl[13] = mk(4'b0010, 4'b0010, 4'b0010, 0, 8'hC1, 0, 1, 1, 1, 1, 0, 8'hC1, 4'b0000);
        tbl[14] = mk(4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000);
        tbl[15] = mk(4'b0010, 4'b0010, 4'b0000, 0, 8'hD1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0010);
        tbl[16] = mk(4'b0010, 4'b0010, 4'b0000, 0, 8'hD1, 0, 1, 1, 1, 0, 0, 8'hD1, 4'b0010);
        tbl[17] = mk(4'b0110, 4'b0100, 4'b0000, 1, 8'hD2, 0, 1, 1, 0, 0, 0, 8'hD2, 4'b0010);
        tbl[18] = mk(4'b0110, 4'b0100, 4'b0000, 1, 8'hD3, 0, 1, 1, 0, 0, 0, 8'hD3, 4'b0010);
        tbl[19] = mk(4'b0110, 4'b0100, 4'b0000, 1, 8'hD4, 0, 1, 1, 0, 0, 0, 8'hD4, 4'b0010);
        tbl[20] = mk(4'b0110, 4'b0100, 4'b0010, 1, 8'hD5, 3, 1, 1, 0, 1, 3, 8'hD5, 4'b0000);
        tbl[21] = mk(4'b0100, 4'b0100, 4'b0100, 1, 8'hE1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000);
        tbl[22] = mk(4'b0100, 4'b0100, 4'b0100, 1, 8'hE1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000);
        tbl[23] = mk(4'b0100, 4'b0100, 4'b0100, 0, 8'hE1, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0100);
        tbl[24] = mk(4'b0100, 4'b0100, 4'b0100, 0, 8'hE1, 0, 1, 2, 1, 1, 0, 8'hE1, 4'b0000);
        tbl[25] = mk(4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000);

        // Asynchronous reset in the middle of a packet on source 1.
        drive(4'b0, 4'b0, 4'b0, 1'b0, 8'h00, 6'd0);
        #12 rst = 1'b0;
        drive(4'b0010, 4'b0010, 4'b0000, 1'b0, 8'h77, 6'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sop", 32'(out_sop), 32'd0);
        chk("rst_out_eop", 32'(out_eop), 32'd0);
        chk("rst_out_empty", 32'(out_empty), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_data", out_data[31:0], 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cur_grant", 32'(cur_grant), 32'd0);
        drive(4'b0, 4'b0, 4'b0, 1'b0, 8'h00, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid || out_eop || cur_grant != 4'b0) vcnt++;
        end
        chk("idle_after_rst_activity", 32'(vcnt), 32'd0);

        // Table-driven directed cycles.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].af, tbl[i].dat, tbl[i].emp);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_grant", i), 32'(cur_grant), 32'(tbl[i].e_grant));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_grant));
            chk($sformatf("v%0d_sop", i), 32'(out_sop), 32'(tbl[i].e_sop));
            chk($sformatf("v%0d_eop", i), 32'(out_eop), 32'(tbl[i].e_eop));
            chk($sformatf("v%0d_empty", i), 32'(out_empty), 32'(tbl[i].e_emp));
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_src", i), 32'(out_src), 32'(tbl[i].e_src));
                chk($sformatf("v%0d_data", i), 32'(out_data[15:0]), 32'({8'(tbl[i].e_src), tbl[i].e_data}));
            end
        end

        // Fairness: all sources continuously offer 2-beat packets.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b[i]   = 0;
            cnt[i] = 0;
        end
        pkts = 0;
        sops = 0;
        for (int cyc = 0; cyc < 400 && pkts < 32; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                sp[i] = (b[i] == 0);
                ep[i] = (b[i] == 1);
            end
            drive(4'b1111, sp, ep, 1'b0, 8'h55, 6'd0);
            rdy = in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (rdy[i]) b[i] = 1 - b[i];
            if (out_valid && out_sop) begin
                chk($sformatf("rr_order_%0d", sops), 32'(out_src), 32'(sops % 4));
                sops++;
            end
            if (out_valid && out_eop) begin
                cnt[out_src]++;
                pkts++;
            end
        end
        chk("rr_packets_done", 32'(pkts), 32'd32);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_count_src%0d", i), 32'(cnt[i]), 32'd8);

        // Sources 0 and 3 stream single-beat packets back to back.
        do_reset();
`ifdef PKT_ARB_NOGAP_EN
        nv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ns = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
`else
        nv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ns = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
`endif
        drive(4'b1001, 4'b1001, 4'b1001, 1'b0, 8'h3C, 6'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_valid_%0d", k), 32'(out_valid), 32'(nv[k]));
            if (nv[k]) chk($sformatf("b2b_src_%0d", k), 32'(out_src), 32'(ns[k]));
        end
        drive(4'b0, 4'b0, 4'b0, 1'b0, 8'h00, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arb_af.md
Name: pkt_rr_arb_af

Overview:
- Packet-boundary round-robin arbiter that merges NUM_IN Avalon-ST packet sources onto one output stream.
- The output stream has no ready signal. The arbiter paces it with the downstream out_almost_full flag.
- A grant is held from grant until the granted source's eop has been accepted, so packets never interleave.
- Sits in front of shared FIFOs and pattern-matcher lanes, wherever several packet producers feed one consumer.

Parameters:
- NUM_IN, 4, number of requesting input streams (2..16).
- DWIDTH, 512, data bus width per stream.
- EWIDTH, 6, empty field width.
- SWIDTH, 2, width of the source-index field; must satisfy 2**SWIDTH >= NUM_IN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_data  in  NUM_IN*DWIDTH  packed data; source i occupies bits [i*DWIDTH +: DWIDTH]
- in_sop  in  NUM_IN  start of packet, per source
- in_eop  in  NUM_IN  end of packet, per source
- in_empty  in  NUM_IN*EWIDTH  packed empty field, per source
- in_valid  in  NUM_IN  per-source valid; also acts as the request
- in_ready  out  NUM_IN  per-source ready; one-hot or zero
- out_data  out  DWIDTH  merged data
- out_sop  out  1  start of packet
- out_eop  out  1  end of packet
- out_empty  out  EWIDTH  empty field
- out_valid  out  1  output valid
- out_src  out  SWIDTH  index of the source of the current beat
- out_almost_full  in  1  downstream almost-full; no backpressure beyond this
- cur_grant  out  NUM_IN  one-hot grant, for debug and statistics

Behaviour:
- Reset values: all out_* = 0, in_ready = 0, cur_grant = 0, state = IDLE, round-robin pointer = 0.
- Reset is asynchronous. Asserting rst mid-packet aborts the packet; no eop is emitted for it.
- States:
  - IDLE: no grant is held.
  - LOCK: cur_grant is one-hot and the packet is in flight.
- IDLE -> LOCK when !out_almost_full && |in_valid.
  - Winner = first i with in_valid[i], scanning from ptr, ptr+1, ... modulo NUM_IN.
  - ptr is then set to winner+1, wrapping from NUM_IN-1 to 0.
- in_ready[i] = (state==LOCK) && cur_grant[i]. It is combinational from registers only; there is no path from in_valid to in_ready.
- Beat acceptance = in_valid[g] && in_ready[g], where g is the granted index.
  - On acceptance, the beat's data, sop, eop, empty and g are registered into out_*; out_valid = 1.
  - Otherwise out_valid = 0 and out_sop/out_eop/out_empty = 0. out_data is don't-care.
  - Latency: exactly 1 cycle from acceptance to output.
- LOCK -> IDLE on an accepted beat with eop, regardless of out_almost_full. cur_grant clears in the same edge.
- out_almost_full is sampled only in IDLE. A packet in flight always completes, so the downstream almost-full threshold must leave room for one maximum-length packet plus 2 beats.
- Valid gaps in the granted source are allowed; the grant is held until eop.
- Other sources' in_valid are ignored while in LOCK.
- Single-beat packet (sop && eop in the same beat): LOCK lasts one cycle.
- No protocol checking. A granted source whose first beat lacks sop is forwarded unchanged.
- Without the optional feature, consecutive packets are separated by at least one idle (IDLE) cycle.

Optional Feature:
- Macro: PKT_ARB_NOGAP_EN.
- When defined:
  - On an accepted eop beat, if !out_almost_full and some other source j != g has in_valid[j], the arbiter re-arbitrates in the same cycle, starting the scan from ptr.
  - It loads the new one-hot grant and stays in LOCK, giving back-to-back packets with zero idle cycles.
  - The current source g is excluded from that same-cycle scan; it is granted again only via IDLE or a later round.
- When undefined: the rule above is absent and every eop returns to IDLE (one bubble per packet).

Test Plan:
- Reset state: drive rst=1 asynchronously mid-cycle -> all outputs 0 immediately; after release with no in_valid, out_valid stays 0 for 20 cycles.
- Basic grant: source 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3) with almost_full=0 -> grant one cycle later; out_valid on 3 consecutive cycles with out_src=2; out_sop on the 0xA1 beat; out_eop on the 0xA3 beat with empty=5; state returns to IDLE.
- Round-robin fairness: all 4 sources hold 2-beat packets continuously for 32 packets -> grant order 0,1,2,3,0,... and each source receives exactly 8 packets.
- Almost-full hold: assert out_almost_full while source 1 is mid-way through a 5-beat packet -> all 5 beats delivered, then no new grant until almost_full drops; first grant 1 cycle after the drop, to source 2 if it is requesting.
- Valid gaps and single-beat: granted source 0 deasserts in_valid for 4 cycles mid-packet -> grant held, out_valid=0 for those cycles, no other source granted; a sop+eop single-beat packet -> LOCK lasts one cycle.
- PKT_ARB_NOGAP_EN: sources 0 and 3 send back-to-back 1-beat packets -> alternating 0,3,0,3 outputs with out_valid=1 every cycle; without the macro, one idle cycle appears between packets.
